// File: rtl/csi2_packet_decoder_if.sv
// csi2_packet_decoder_if
// Bundles the lane-aligned input word stream and the decoded outputs of
// csi2_packet_decoder.
//   lane_valid, lane_data       : aligned word from the byte aligner (byte i = lane i)
//   mipi_data_enable, mipi_data : forwarded payload word to the frame arbiter
//   frame_start .. line_end     : sync pulses
//   header_error, truncated,
//   crc_error                   : error pulses
// Modports: master = stream source / sink side, slave = decoder side.
interface csi2_packet_decoder_if;
   logic            lane_valid;
   logic [0:3][7:0] lane_data;
   logic            mipi_data_enable;
   logic [0:3][7:0] mipi_data;
   logic            frame_start;
   logic            frame_end;
   logic            line_start;
   logic            line_end;
   logic            header_error;
   logic            truncated;
   logic            crc_error;

   modport master (
      output lane_valid, lane_data,
      input  mipi_data_enable, mipi_data, frame_start, frame_end, line_start,
             line_end, header_error, truncated, crc_error
   );

   modport slave (
      input  lane_valid, lane_data,
      output mipi_data_enable, mipi_data, frame_start, frame_end, line_start,
             line_end, header_error, truncated, crc_error
   );
endinterface

// File: rtl/csi2_packet_decoder.sv
// csi2_packet_decoder
// Parses CSI-2 short and long packets from 4-lane aligned byte words, forwards
// the payload of the selected image long packets and reports sync / error pulses.
// All outputs are registered, 1 cycle latency from input word.
// Ports:
//   mipi_clk : clock, all logic on posedge
//   reset    : synchronous, active-high
//   csi      : csi2_packet_decoder_if.slave (input word stream, decoded outputs)
// Parameters:
//   VIRTUAL_CHANNEL : VC acted on
//   DATA_TYPE       : long-packet data type forwarded
// Build option:
//   CSI2_CRC_CHECK_EN : when defined, payload CRC-16 is checked and reported on
//                       crc_error; otherwise the CRC word is skipped and
//                       crc_error is tied low.
//
// state   | meaning
// IDLE    | waiting for a packet header word
// PAYLOAD | counting (and optionally forwarding) long-packet payload words
// CRC     | next valid word carries the packet CRC
// DRAIN   | packet done, ignore filler until lane_valid drops
module csi2_packet_decoder #(
   parameter logic [1:0] VIRTUAL_CHANNEL = 2'd0,
   parameter logic [5:0] DATA_TYPE       = 6'h2A
) (
   input logic                  mipi_clk,
   input logic                  reset,
   csi2_packet_decoder_if.slave csi
);

   typedef enum logic [1:0] {IDLE, PAYLOAD, CRC, DRAIN} state_t;

   // CSI-2 header Hamming parity, one mask per parity bit over {WC, DI}
   function automatic logic [5:0] ecc_calc(input logic [23:0] d);
      logic [5:0] p;
      p[0] = ^(d & 24'hF12CB7);
      p[1] = ^(d & 24'hF2555B);
      p[2] = ^(d & 24'h749A6D);
      p[3] = ^(d & 24'hB8E38E);
      p[4] = ^(d & 24'hDF03F0);
      p[5] = ^(d & 24'hEFFC00);
      return p;
   endfunction

   state_t          state_q, state_d;
   logic [13:0]     count_q, count_d;
   logic            fwd_q, fwd_d;
   logic            en_q, en_d;
   logic [0:3][7:0] data_q, data_d;
   logic            fs_q, fs_d, fe_q, fe_d, ls_q, ls_d, le_q, le_d;
   logic            herr_q, herr_d, trunc_q, trunc_d;

   logic [7:0]      di;
   logic [15:0]     wc;
   logic [7:0]      ecc;
   logic            vc_match;
   logic            ecc_ok;

   assign di       = csi.lane_data[0];
   assign wc       = {csi.lane_data[2], csi.lane_data[1]};
   assign ecc      = csi.lane_data[3];
   assign vc_match = (di[7:6] == VIRTUAL_CHANNEL);
   assign ecc_ok   = (ecc[7:6] == 2'b00) && (ecc[5:0] == ecc_calc({wc, di}));

`ifdef CSI2_CRC_CHECK_EN
   // CRC-16, poly 0x1021 reflected, LSB of each byte first, bytes in stream order
   function automatic logic [15:0] crc_word(input logic [15:0] c_in,
                                            input logic [0:3][7:0] w);
      logic [15:0] c;
      c = c_in;
      for (int b = 0; b < 4; b++) begin
         for (int i = 0; i < 8; i++) begin
            if (c[0] ^ w[b][i]) c = (c >> 1) ^ 16'h8408;
            else                c = c >> 1;
         end
      end
      return c;
   endfunction

   logic [15:0] crc_q, crc_d;
   logic        crc_err_q, crc_err_d;
`endif

   always_comb begin
      state_d = state_q;
      count_d = count_q;
      fwd_d   = fwd_q;
      en_d    = 1'b0;
      data_d  = data_q;
      fs_d    = 1'b0;
      fe_d    = 1'b0;
      ls_d    = 1'b0;
      le_d    = 1'b0;
      herr_d  = 1'b0;
      trunc_d = 1'b0;
`ifdef CSI2_CRC_CHECK_EN
      crc_d     = crc_q;
      crc_err_d = 1'b0;
`endif
      case (state_q)
         IDLE: begin
            if (csi.lane_valid) begin
               state_d = DRAIN;
               if (!ecc_ok) begin
                  herr_d = 1'b1;
               end else if (di[5:0] <= 6'h0F) begin
                  if (vc_match) begin
                     case (di[5:0])
                        6'h00:   fs_d = 1'b1;
                        6'h01:   fe_d = 1'b1;
                        6'h02:   ls_d = 1'b1;
                        6'h03:   le_d = 1'b1;
                        default: ;
                     endcase
                  end
               end else if ((wc == 16'd0) || (wc[1:0] != 2'b00)) begin
                  herr_d = 1'b1;
               end else begin
                  count_d = wc[15:2];
                  fwd_d   = vc_match && (di[5:0] == DATA_TYPE);
                  state_d = PAYLOAD;
`ifdef CSI2_CRC_CHECK_EN
                  crc_d   = 16'hFFFF;
`endif
               end
            end
         end
         PAYLOAD: begin
            if (!csi.lane_valid) begin
               trunc_d = 1'b1;
               state_d = IDLE;
            end else begin
               count_d = count_q - 14'd1;
               if (fwd_q) begin
                  en_d   = 1'b1;
                  data_d = csi.lane_data;
               end
`ifdef CSI2_CRC_CHECK_EN
               crc_d = crc_word(crc_q, csi.lane_data);
`endif
               if (count_q == 14'd1) state_d = CRC;
            end
         end
         CRC: begin
            // CRC lasts exactly one cycle, so this lands one cycle after the last payload word
            le_d = fwd_q;
            if (!csi.lane_valid) begin
               trunc_d = 1'b1;
               state_d = IDLE;
            end else begin
`ifdef CSI2_CRC_CHECK_EN
               crc_err_d = ({csi.lane_data[1], csi.lane_data[0]} != crc_q);
`endif
               state_d = DRAIN;
            end
         end
         DRAIN: begin
            if (!csi.lane_valid) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge mipi_clk) begin
      if (reset) begin
         state_q <= IDLE;
         count_q <= '0;
         fwd_q   <= 1'b0;
         en_q    <= 1'b0;
         data_q  <= '0;
         fs_q    <= 1'b0;
         fe_q    <= 1'b0;
         ls_q    <= 1'b0;
         le_q    <= 1'b0;
         herr_q  <= 1'b0;
         trunc_q <= 1'b0;
      end else begin
         state_q <= state_d;
         count_q <= count_d;
         fwd_q   <= fwd_d;
         en_q    <= en_d;
         data_q  <= data_d;
         fs_q    <= fs_d;
         fe_q    <= fe_d;
         ls_q    <= ls_d;
         le_q    <= le_d;
         herr_q  <= herr_d;
         trunc_q <= trunc_d;
      end
   end

`ifdef CSI2_CRC_CHECK_EN
   always_ff @(posedge mipi_clk) begin
      if (reset) begin
         crc_q     <= 16'hFFFF;
         crc_err_q <= 1'b0;
      end else begin
         crc_q     <= crc_d;
         crc_err_q <= crc_err_d;
      end
   end
   assign csi.crc_error = crc_err_q;
`else
   assign csi.crc_error = 1'b0;
`endif

   assign csi.mipi_data_enable = en_q;
   assign csi.mipi_data        = data_q;
   assign csi.frame_start      = fs_q;
   assign csi.frame_end        = fe_q;
   assign csi.line_start       = ls_q;
   assign csi.line_end         = le_q;
   assign csi.header_error     = herr_q;
   assign csi.truncated        = trunc_q;

endmodule

// File: tb/tb_csi2_packet_decoder.sv
// tb_csi2_packet_decoder
// Directed bench for csi2_packet_decoder: each driven word pushes the output it
// should produce one cycle later onto a scoreboard queue; the queue is popped
// and compared on the following falling edge.
module tb_csi2_packet_decoder;

   typedef logic [0:3][7:0] word_t;
   typedef struct packed {
      logic       en;
      word_t      data;
      logic [6:0] flags;   // {fs, fe, ls, le, header_error, truncated, crc_error}
   } exp_t;

   localparam logic [6:0] NONE  = 7'b0000000;
   localparam logic [6:0] FS    = 7'b1000000;
   localparam logic [6:0] FE    = 7'b0100000;
   localparam logic [6:0] LS    = 7'b0010000;
   localparam logic [6:0] LE    = 7'b0001000;
   localparam logic [6:0] HERR  = 7'b0000100;
   localparam logic [6:0] TRUNC = 7'b0000010;
   localparam logic [6:0] CRCE  = 7'b0000001;

   logic mipi_clk = 1'b0;
   logic reset    = 1'b1;

   csi2_packet_decoder_if bus();

   csi2_packet_decoder #(
      .VIRTUAL_CHANNEL (2'd0),
      .DATA_TYPE       (6'h2A)
   ) dut (
      .mipi_clk (mipi_clk),
      .reset    (reset),
      .csi      (bus)
   );

   always #5 mipi_clk = ~mipi_clk;

   exp_t       sb[$];
   int         vectors    = 0;
   int         miscompares = 0;
   logic [7:0] next_byte;

   // Header parity from the per-bit syndrome table
   function automatic logic [5:0] ecc_ref(input logic [7:0] di, input logic [15:0] wc);
      logic [5:0]  col [0:23];
      logic [23:0] d;
      logic [5:0]  e;
      col = '{6'h07, 6'h0B, 6'h0D, 6'h0E, 6'h13, 6'h15, 6'h16, 6'h19,
              6'h1A, 6'h1C, 6'h23, 6'h25, 6'h26, 6'h29, 6'h2A, 6'h2C,
              6'h31, 6'h32, 6'h34, 6'h38, 6'h1F, 6'h2F, 6'h37, 6'h3B};
      d = {wc, di};
      e = '0;
      for (int i = 0; i < 24; i++) if (d[i]) e = e ^ col[i];
      return e;
   endfunction

   function automatic word_t hdr(input logic [7:0] di, input logic [15:0] wc);
      word_t w;
      w[0] = di;
      w[1] = wc[7:0];
      w[2] = wc[15:8];
      w[3] = {2'b00, ecc_ref(di, wc)};
      return w;
   endfunction

   function automatic logic [15:0] rev16(input logic [15:0] x);
      logic [15:0] r;
      for (int i = 0; i < 16; i++) r[i] = x[15 - i];
      return r;
   endfunction

   // Reflected CRC-16 computed with a bit-reversed, non-reflected shift register
   function automatic logic [15:0] crc_byte(input logic [15:0] crc, input logic [7:0] b);
      logic [15:0] r;
      logic        fb;
      r = rev16(crc);
      for (int i = 0; i < 8; i++) begin
         fb = r[15] ^ b[i];
         r  = {r[14:0], 1'b0};
         if (fb) r = r ^ 16'h1021;
      end
      return rev16(r);
   endfunction

   task automatic check_pending();
      exp_t       e;
      logic [6:0] obs;
      if (sb.size() > 0) begin
         e   = sb.pop_front();
         obs = {bus.frame_start, bus.frame_end, bus.line_start, bus.line_end,
                bus.header_error, bus.truncated, bus.crc_error};
         vectors++;
         assert (obs === e.flags) else begin
            miscompares++;
            $error("FAIL flags: got %b expected %b", obs, e.flags);
         end
         vectors++;
         assert (bus.mipi_data_enable === e.en) else begin
            miscompares++;
            $error("FAIL enable: got %b expected %b", bus.mipi_data_enable, e.en);
         end
         if (e.en) begin
            vectors++;
            assert (bus.mipi_data === e.data) else begin
               miscompares++;
               $error("FAIL data: got %h expected %h", bus.mipi_data, e.data);
            end
         end
      end
   endtask

   task automatic cyc(input logic rst, input logic v, input word_t d,
                      input logic en_e, input word_t d_e, input logic [6:0] fl_e);
      exp_t e;
      @(negedge mipi_clk);
      check_pending();
      reset          = rst;
      bus.lane_valid = v;
      bus.lane_data  = d;
      e.en    = en_e;
      e.data  = d_e;
      e.flags = fl_e;
      sb.push_back(e);
   endtask

   task automatic put(input logic v, input word_t d, input logic [6:0] fl);
      cyc(1'b0, v, d, 1'b0, '0, fl);
   endtask

   task automatic fwd(input word_t d);
      cyc(1'b0, 1'b1, d, 1'b1, d, NONE);
   endtask

   function automatic word_t next_word();
      word_t w;
      for (int b = 0; b < 4; b++) begin
         w[b]      = next_byte;
         next_byte = next_byte + 8'd1;
      end
      return w;
   endfunction

   // Full long-packet burst: header, payload, CRC word, one filler word, lane_valid low
   task automatic long_pkt(input logic [7:0] di, input logic [15:0] wc,
                           input bit fwd_e, input bit bad_crc);
      logic [15:0] crc;
      word_t       w;
      word_t       cw;
      logic [6:0]  fl;
      crc = 16'hFFFF;
      put(1'b1, hdr(di, wc), NONE);
      for (int k = 0; k < int'(wc) / 4; k++) begin
         w = next_word();
         for (int b = 0; b < 4; b++) crc = crc_byte(crc, w[b]);
         if (fwd_e) fwd(w);
         else       put(1'b1, w, NONE);
      end
      cw[0] = crc[7:0] ^ {7'b0, bad_crc};
      cw[1] = crc[15:8];
      cw[2] = 8'hA5;
      cw[3] = 8'h5A;
      fl = fwd_e ? LE : NONE;
`ifdef CSI2_CRC_CHECK_EN
      if (bad_crc) fl = fl | CRCE;
`endif
      put(1'b1, cw, fl);
      put(1'b1, hdr(8'h00, 16'h0000), NONE);
      put(1'b0, '0, NONE);
   endtask

   initial begin
      word_t w;
      bus.lane_valid = 1'b0;
      bus.lane_data  = '0;
      reset          = 1'b1;

      // reset state
      for (int i = 0; i < 3; i++) cyc(1'b1, 1'b0, '0, 1'b0, '0, NONE);
      put(1'b0, '0, NONE);

      // frame start {00,00,00,00}
      put(1'b1, hdr(8'h00, 16'h0000), FS);
      put(1'b0, '0, NONE);

      // forwarded RAW8 line, bytes 00..0F
      next_byte = 8'h00;
      long_pkt(8'h2A, 16'h0010, 1'b1, 1'b0);

      // header bit 3 flipped: error, payload not forwarded, then back to IDLE
      w = hdr(8'h2A, 16'h0010);
      w[0][3] = ~w[0][3];
      put(1'b1, w, HERR);
      for (int k = 0; k < 5; k++) put(1'b1, next_word(), NONE);
      put(1'b0, '0, NONE);
      put(1'b1, hdr(8'h00, 16'h0000), FS);
      put(1'b0, '0, NONE);

      // long packets consumed silently: other DT, other VC
      long_pkt(8'h2B, 16'h0010, 1'b0, 1'b0);
      long_pkt(8'h6A, 16'h0010, 1'b0, 1'b0);

      // truncation after 2 of 4 payload words
      put(1'b1, hdr(8'h2A, 16'h0010), NONE);
      fwd(next_word());
      fwd(next_word());
      put(1'b0, '0, TRUNC);
      put(1'b1, hdr(8'h00, 16'h0000), FS);
      put(1'b0, '0, NONE);

      // remaining short packets, reserved short DT, VC mismatch
      put(1'b1, hdr(8'h01, 16'h0003), FE);
      put(1'b0, '0, NONE);
      put(1'b1, hdr(8'h02, 16'h0005), LS);
      put(1'b0, '0, NONE);
      put(1'b1, hdr(8'h03, 16'h0005), LE);
      put(1'b0, '0, NONE);
      put(1'b1, hdr(8'h05, 16'h1234), NONE);
      put(1'b0, '0, NONE);
      put(1'b1, hdr(8'h40, 16'h0000), NONE);
      put(1'b0, '0, NONE);

      // word count not a multiple of 4, zero word count, ECC top bits set
      put(1'b1, hdr(8'h2A, 16'h0011), HERR);
      put(1'b1, next_word(), NONE);
      put(1'b0, '0, NONE);
      put(1'b1, hdr(8'h2A, 16'h0000), HERR);
      put(1'b1, next_word(), NONE);
      put(1'b0, '0, NONE);
      w = hdr(8'h00, 16'h0000);
      w[3][7] = 1'b1;
      put(1'b1, w, HERR);
      put(1'b0, '0, NONE);

      // single-word forwarded packet, then a bad-CRC packet
      long_pkt(8'h2A, 16'h0004, 1'b1, 1'b0);
      long_pkt(8'h2A, 16'h0008, 1'b1, 1'b1);

      // reset mid-payload drops the packet
      put(1'b1, hdr(8'h2A, 16'h0010), NONE);
      fwd(next_word());
      fwd(next_word());
      cyc(1'b1, 1'b1, next_word(), 1'b0, '0, NONE);
      put(1'b0, '0, NONE);
      put(1'b1, hdr(8'h00, 16'h0000), FS);
      put(1'b0, '0, NONE);

      @(negedge mipi_clk);
      check_pending();

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
